// File: rtl/multicycle_control_if.sv
// multicycle_control_if: opcode/flag inputs and datapath strobes of the LEGv8 multicycle control FSM.
interface multicycle_control_if #(parameter int CNT_W = 32);
    logic [10:0]      Opcode;
    logic             ALUZero;
    logic             MemReady;
    logic             IRWrite;
    logic             PCWrite;
    logic             BranchTaken;
    logic             Reg2Loc;
    logic             ALUSrc;
    logic [1:0]       ALUOp;
    logic             MemRead;
    logic             MemWrite;
    logic             MemToReg;
    logic             RegWrite;
    logic             Illegal;
    logic [3:0]       State;
    logic [CNT_W-1:0] InstrCount;
    modport master (
        output Opcode, ALUZero, MemReady,
        input  IRWrite, PCWrite, BranchTaken, Reg2Loc, ALUSrc, ALUOp, MemRead, MemWrite,
        input  MemToReg, RegWrite, Illegal, State, InstrCount
    );
    modport slave (
        input  Opcode, ALUZero, MemReady,
        output IRWrite, PCWrite, BranchTaken, Reg2Loc, ALUSrc, ALUOp, MemRead, MemWrite,
        output MemToReg, RegWrite, Illegal, State, InstrCount
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: LEGv8 multicycle control FSM with memory wait states, retired counter and sticky halt.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input logic                CLK,
    input logic                Reset_L,
    multicycle_control_if.slave bus
);
    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] EX_R    = 4'd2;
    localparam logic [3:0] EX_ADDR = 4'd3;
    localparam logic [3:0] MEM_RD  = 4'd4;
    localparam logic [3:0] MEM_WR  = 4'd5;
    localparam logic [3:0] WB_R    = 4'd6;
    localparam logic [3:0] WB_LD   = 4'd7;
    localparam logic [3:0] BR_CBZ  = 4'd8;
    localparam logic [3:0] BR_B    = 4'd9;
    localparam logic [3:0] HALT    = 4'd10;

    logic [3:0]       r_state, w_next;
    logic [CNT_W-1:0] r_count;
    logic             w_ldur, w_stur, w_rtype, w_cbz, w_b;
    logic             w_irwrite, w_pcwrite, w_branch, w_reg2loc, w_alusrc;
    logic             w_memread, w_memwrite, w_memtoreg, w_regwrite;
    logic [1:0]       w_aluop;

    assign w_ldur  = bus.Opcode == 11'b11111000010;
    assign w_stur  = bus.Opcode == 11'b11111000000;
    assign w_rtype = bus.Opcode inside {11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
    assign w_cbz   = bus.Opcode[10:3] == 8'b10110100;
    assign w_b     = bus.Opcode[10:5] == 6'b000101;

    always_comb begin
        w_irwrite  = 1'b0;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_reg2loc  = 1'b0;
        w_alusrc   = 1'b0;
        w_aluop    = 2'b00;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_memtoreg = 1'b0;
        w_regwrite = 1'b0;
        w_next     = FETCH;
        case (r_state)
            FETCH: begin
                w_irwrite = 1'b1;
                w_next    = DECODE;
            end
            DECODE: begin
                w_reg2loc = w_stur | w_cbz;
                w_next    = w_rtype ? EX_R : (w_ldur | w_stur) ? EX_ADDR : w_cbz ? BR_CBZ : w_b ? BR_B : HALT;
            end
            EX_R: begin
                w_aluop = 2'b10;
                w_next  = WB_R;
            end
            WB_R: begin
                w_aluop    = 2'b10;
                w_regwrite = 1'b1;
                w_pcwrite  = 1'b1;
            end
            EX_ADDR: begin
                w_alusrc  = 1'b1;
                w_reg2loc = w_stur;
                w_next    = w_stur ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                w_alusrc  = 1'b1;
                w_memread = 1'b1;
                w_next    = bus.MemReady ? WB_LD : MEM_RD;
            end
            WB_LD: begin
                w_alusrc   = 1'b1;
                w_memread  = 1'b1;
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
                w_pcwrite  = 1'b1;
            end
            MEM_WR: begin
                w_alusrc   = 1'b1;
                w_reg2loc  = 1'b1;
                w_memwrite = 1'b1;
                w_pcwrite  = bus.MemReady;
                w_next     = bus.MemReady ? FETCH : MEM_WR;
            end
            BR_CBZ: begin
                w_reg2loc = 1'b1;
                w_aluop   = 2'b01;
                w_pcwrite = 1'b1;
                w_branch  = bus.ALUZero;
            end
            BR_B: begin
                w_pcwrite = 1'b1;
                w_branch  = 1'b1;
            end
            HALT: w_next = HALT;
            default: w_next = FETCH;
        endcase
    end

    // Strobes are masked while reset is held so an abandoned instruction commits nothing.
    assign bus.IRWrite     = Reset_L & w_irwrite;
    assign bus.PCWrite     = Reset_L & w_pcwrite;
    assign bus.BranchTaken = Reset_L & w_branch;
    assign bus.Reg2Loc     = Reset_L & w_reg2loc;
    assign bus.ALUSrc      = Reset_L & w_alusrc;
    assign bus.ALUOp       = Reset_L ? w_aluop : 2'b00;
    assign bus.MemRead     = Reset_L & w_memread;
    assign bus.MemWrite    = Reset_L & w_memwrite;
    assign bus.MemToReg    = Reset_L & w_memtoreg;
    assign bus.RegWrite    = Reset_L & w_regwrite;
    assign bus.Illegal     = r_state == HALT;
    assign bus.State       = r_state;
    assign bus.InstrCount  = r_count;

    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            r_state <= FETCH;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_pcwrite && !(&r_count))
                r_count <= r_count + 1'b1;
        end
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle control FSM for the LEGv8 datapath (register file, sign extender, ALU, data memory, next-PC logic).
- Replaces the single-cycle combinational control by sequencing each instruction over several clocks. Lets the ALU and data memory be reused across phases and tolerates a data memory that needs wait states.
- Emits datapath strobes every cycle, a retired-instruction counter, and a sticky illegal-opcode halt.

Parameters:
- CNT_W, 32, width of retired-instruction counter InstrCount.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- Reset_L  in  1  reset, synchronous, active-low.
- Opcode  in  11  instruction bits [31:21] from the instruction register; stable from DECODE onward.
- ALUZero  in  1  ALU zero flag.
- MemReady  in  1  data memory handshake; 1 = access completes this cycle.
- IRWrite  out  1  load instruction register.
- PCWrite  out  1  load PC with next-PC value this edge.
- BranchTaken  out  1  next-PC selects PC+SignExtImm64 (else PC+4); meaningful only when PCWrite=1.
- Reg2Loc  out  1  RB index select: 1 = Rt field [4:0], 0 = Rm field.
- ALUSrc  out  1  ALU B operand: 1 = sign-extended immediate, 0 = BusB.
- ALUOp  out  2  00 = add (address), 01 = pass B (CBZ), 10 = R-type function from opcode.
- MemRead  out  1  data memory read strobe.
- MemWrite  out  1  data memory write strobe.
- MemToReg  out  1  BusW select: 1 = memory data, 0 = ALU result.
- RegWrite  out  1  register file write enable.
- Illegal  out  1  sticky, unsupported opcode seen.
- State  out  4  current state encoding, for debug.
- InstrCount  out  CNT_W  instructions retired since reset.

Behaviour:
- Reset: a rising edge with Reset_L=0 sets State=FETCH and InstrCount=0, and clears Illegal. While Reset_L=0 all strobes are forced to 0 combinationally. Asserting reset mid-instruction abandons it: no PCWrite, RegWrite or MemWrite on that edge.
- Decode, in DECODE:
  - LDUR = 11111000010.
  - STUR = 11111000000.
  - R-type = ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
  - CBZ = Opcode[10:3]==10110100.
  - B = Opcode[10:5]==000101.
  - Anything else → HALT.
- State encodings: FETCH=0, DECODE=1, EX_R=2, EX_ADDR=3, MEM_RD=4, MEM_WR=5, WB_R=6, WB_LD=7, BR_CBZ=8, BR_B=9, HALT=10. Codes 11–15 → FETCH on the next edge with all strobes 0.
- Default every strobe is 0. Per state:
  - FETCH: IRWrite=1 → DECODE.
  - DECODE: Reg2Loc=1 if STUR/CBZ. Next: R-type→EX_R; LDUR/STUR→EX_ADDR; CBZ→BR_CBZ; B→BR_B; else→HALT.
  - EX_R: ALUSrc=0, ALUOp=10 → WB_R.
  - WB_R: ALUSrc=0, ALUOp=10, RegWrite=1, MemToReg=0, PCWrite=1 → FETCH.
  - EX_ADDR: ALUSrc=1, ALUOp=00, Reg2Loc=1 if STUR. LDUR→MEM_RD, STUR→MEM_WR.
  - MEM_RD: ALUSrc=1, ALUOp=00, MemRead=1. Stay while MemReady=0; MemReady=1 → WB_LD.
  - WB_LD: ALUSrc=1, ALUOp=00, MemRead=1, MemToReg=1, RegWrite=1, PCWrite=1 → FETCH.
  - MEM_WR: ALUSrc=1, ALUOp=00, Reg2Loc=1, MemWrite=1. Stay while MemReady=0. On MemReady=1: PCWrite=1 in the same cycle (Mealy) → FETCH.
  - BR_CBZ: Reg2Loc=1, ALUSrc=0, ALUOp=01, PCWrite=1, BranchTaken=ALUZero (Mealy) → FETCH.
  - BR_B: PCWrite=1, BranchTaken=1 → FETCH.
  - HALT: Illegal=1, all strobes 0, State held until reset.
- Latency in cycles, FETCH to FETCH: R-type 4; LDUR 5+w; STUR 4+w; CBZ 3; B 3. w = number of cycles with MemReady=0 in the memory state.
- MemReady is ignored outside MEM_RD/MEM_WR.
- InstrCount increments by 1 on every edge where PCWrite=1, and saturates at all-ones without wrapping.
- Exactly one PCWrite pulse per retired instruction. MemRead and MemWrite are never both 1.

Test Plan:
- Reset, then ADD (10001011000) → states 0,1,2,6,0. RegWrite=1 and PCWrite=1 only in WB_R, BranchTaken=0. InstrCount=1 after the WB_R edge.
- LDUR with MemReady low for 3 cycles → MEM_RD held 4 cycles with MemRead=1 throughout. WB_LD asserts MemToReg=RegWrite=1. Total 8 cycles; no RegWrite before WB_LD.
- STUR with MemReady=1 on first MEM_WR cycle → MemWrite=1 and PCWrite=1 together in that cycle, Reg2Loc=1. 4 cycles total, RegWrite never 1.
- CBZ with ALUZero=1, then CBZ with ALUZero=0 → BranchTaken=1, then 0, in BR_CBZ. 3 cycles each; InstrCount +2.
- Opcode 00000000000 → HALT after DECODE, Illegal=1, strobes 0 for 20 cycles. Reset clears Illegal and returns to FETCH.
- Reset_L=0 during MEM_WR with MemReady=1 → MemWrite=0, PCWrite=0 that cycle. Next State=FETCH, InstrCount=0.
- CNT_W=4, run 17 B instructions → InstrCount saturates at 15.
